// File: rtl/pacman_map_loader_if.sv
// Byte-stream and memory port-A signals between the loader and its neighbours.
// The loader consumes the stream and drives the memory port (slave side).
interface pacman_map_loader_if #(
    parameter int ADDR_W = 6,
    parameter int MEM_W  = 128
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [MEM_W-1:0]  dina;

    modport slave (
        input  s_data, s_valid,
        output s_ready, ena, wea, addra, dina
    );

    modport master (
        output s_data, s_valid,
        input  s_ready, ena, wea, addra, dina
    );
endinterface

// File: rtl/pacman_map_loader.sv
// Assembles 10-byte rows from a byte stream and writes all maze rows into the
// map block memory, one memory write per row, with the top bits zero-padded.
module pacman_map_loader #(
    parameter int ROWS     = 64,
    parameter int ADDR_W   = 6,
    parameter int ROW_BITS = 80,
    parameter int MEM_W    = 128
) (
    input  logic               clka,
    input  logic               rsta_n,
    input  logic               start,
    input  logic               abort,
    pacman_map_loader_if.slave bus,
    output logic               busy,
    output logic               done
);
    localparam int          NBYTES    = ROW_BITS / 8;
    localparam logic [3:0]  BYTE_LAST = 4'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [3:0]          byte_cnt_reg;
    logic [ADDR_W-1:0]   row_cnt_reg;
    // Only the first NBYTES-1 bytes need storing; the last byte goes straight into dina.
    logic [ROW_BITS-9:0] shift_reg;
    logic [ROW_BITS-1:0] shift_next;
    logic [ADDR_W-1:0]   addra_reg;
    logic [MEM_W-1:0]    dina_reg;
    logic                accept;
    logic                last_byte;

    assign shift_next = {shift_reg, bus.s_data};
    assign accept     = (state_reg == S_RECV) && bus.s_valid && !abort;
    assign last_byte  = accept && (byte_cnt_reg == BYTE_LAST);
    assign bus.addra  = addra_reg;
    assign bus.dina   = dina_reg;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bus.s_ready = 1'b0;
        bus.ena     = 1'b0;
        bus.wea     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RECV;
                end
            end
            S_RECV: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (last_byte) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy       = 1'b1;
                bus.ena    = !abort;
                bus.wea    = !abort;
                state_next = (row_cnt_reg == ROW_LAST) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done       = !abort;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // Abort overrides every transition, including a start seen in IDLE.
        if (abort) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            byte_cnt_reg <= '0;
            row_cnt_reg  <= '0;
            shift_reg    <= '0;
            addra_reg    <= '0;
            dina_reg     <= '0;
        end else begin
            if (state_reg == S_IDLE && start && !abort) begin
                byte_cnt_reg <= '0;
                row_cnt_reg  <= '0;
                shift_reg    <= '0;
            end
            if (accept) begin
                shift_reg <= shift_next[ROW_BITS-9:0];
                if (last_byte) begin
                    byte_cnt_reg <= '0;
                    // Latch the row here so address and data hold steady after the write.
                    addra_reg    <= row_cnt_reg;
                    dina_reg     <= MEM_W'(shift_next);
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 4'd1;
                end
            end
            if (state_reg == S_WRITE && !abort && row_cnt_reg != ROW_LAST) begin
                row_cnt_reg  <= row_cnt_reg + 1'b1;
                byte_cnt_reg <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pacman_map_loader.sv
// Drives randomized map loads into pacman_map_loader and compares the captured
// memory writes, handshakes and completion pulses with a row-assembly model.
module tb_pacman_map_loader;
    localparam int ROWS = 64;
    localparam int NB   = 640;

    logic clk    = 1'b0;
    logic rsta_n = 1'b0;
    logic start  = 1'b0;
    logic abort  = 1'b0;
    logic busy;
    logic done;

    pacman_map_loader_if #(.ADDR_W(6), .MEM_W(128)) bus ();

    pacman_map_loader #(
        .ROWS(64), .ADDR_W(6), .ROW_BITS(80), .MEM_W(128)
    ) dut (
        .clka  (clk),
        .rsta_n(rsta_n),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [7:0]   src[NB];
    logic [127:0] dut_mem[ROWS];
    bit           wr_flag[ROWS];
    int           wr_addr_q[$];
    int           wr_cnt = 0;
    int           done_cnt = 0;
    int           cycle = 0;
    int           first_ready_cyc = -1;
    int           done_cyc = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe the DUT half a cycle away from the active edge.
    always @(negedge clk) begin
        cycle++;
        if (bus.ena && bus.wea) begin
            dut_mem[bus.addra] = bus.dina;
            wr_flag[bus.addra] = 1'b1;
            wr_addr_q.push_back(int'(bus.addra));
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cycle;
        end
        if (bus.s_ready && first_ready_cyc < 0) first_ready_cyc = cycle;
    end

    // Row r is its 10 bytes concatenated first-byte-most-significant, zero above bit 79.
    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v = '0;
        for (int k = 0; k < 10; k++) v = (v << 8) | 128'(src[10*r + k]);
        return v;
    endfunction

    task automatic clear_log();
        wr_cnt = 0;
        done_cnt = 0;
        first_ready_cyc = -1;
        done_cyc = -1;
        wr_addr_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            wr_flag[r] = 1'b0;
            dut_mem[r] = '0;
        end
    endtask

    task automatic check_mem(input string tag, input int nrows);
        check({tag, "_wr_cnt"}, 128'(wr_cnt), 128'(nrows));
        for (int i = 0; i < wr_addr_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 128'(wr_addr_q[i]), 128'(i));
        for (int r = 0; r < ROWS; r++) begin
            if (r < nrows) check($sformatf("%s_row%0d", tag, r), dut_mem[r], exp_row(r));
            else           check($sformatf("%s_unwritten%0d", tag, r), 128'(wr_flag[r]), 128'(0));
        end
    endtask

    // One load: duty is s_valid probability (%); abort_at / start_at / rst_at are
    // accepted-byte counts at which to abort, re-pulse start, or drop reset (-1 = never).
    task automatic run_load(input int duty, input int abort_at, input int start_at,
                            input int rst_at, output bit finished);
        int idx = 0;
        bit take;
        bit pulsed = 1'b0;
        finished = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start = 1'b0;
            bus.s_valid = (idx < NB) && ($urandom_range(99) < duty);
            bus.s_data  = (idx < NB) ? src[idx] : 8'h00;
            if (start_at >= 0 && idx == start_at && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                abort = 1'b1;
                bus.s_valid = 1'b0;
                @(posedge clk); #1;
                abort = 1'b0;
                @(negedge clk);
                check("abort_busy", 128'(busy), 128'(0));
                check("abort_ready", 128'(bus.s_ready), 128'(0));
                return;
            end
            if (rst_at >= 0 && idx == rst_at) begin
                bus.s_valid = 1'b0;
                #2 rsta_n = 1'b0;
                #1;
                check("arst_ready", 128'(bus.s_ready), 128'(0));
                check("arst_strobe", {126'd0, bus.ena, bus.wea}, 128'(0));
                check("arst_busy_done", {126'd0, busy, done}, 128'(0));
                check("arst_addra", 128'(bus.addra), 128'(0));
                check("arst_dina", bus.dina, 128'(0));
                @(posedge clk); #1;
                rsta_n = 1'b1;
                return;
            end
            @(negedge clk);
            take = bus.s_valid && bus.s_ready;
            if (done_cnt > 0) begin
                finished = 1'b1;
                bus.s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (take) idx++;
        end
        check("load_timeout", 128'(0), 128'(1));
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) src[i] = 8'($urandom);
    endtask

    initial begin
        bit fin;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        clear_log();

        // Reset held with inputs toggling: everything stays at reset values.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom);
            bus.s_valid = 1'($urandom);
            bus.s_data = 8'($urandom);
            @(negedge clk);
            check("rst_outs", {123'd0, bus.ena, bus.wea, bus.s_ready, busy, done}, 128'(0));
            check("rst_addr_dina", {bus.dina[121:0], bus.addra}, 128'(0));
        end
        @(posedge clk); #1;
        start = 1'b0;
        bus.s_valid = 1'b0;
        rsta_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 128'(bus.s_ready), 128'(0));
        check("post_rst_busy", 128'(busy), 128'(0));
        check("rst_no_write", 128'(wr_cnt), 128'(0));

        // start and abort together in IDLE: abort wins.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", 128'(busy), 128'(0));

        // Full gap-free load of the (r + k) pattern.
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < 10; k++) src[10*r + k] = 8'(r + k);
        clear_log();
        run_load(100, -1, -1, -1, fin);
        check("full_finished", 128'(fin), 128'(1));
        check_mem("full", ROWS);
        check("full_row0", dut_mem[0], 128'h0000_0000_0000_0001_0203_0405_0607_0809);
        check("full_done_lat", 128'(done_cyc - first_ready_cyc), 128'(704));
        repeat (4) @(negedge clk);
        check("full_done_once", 128'(done_cnt), 128'(1));
        check("hold_addra", 128'(bus.addra), 128'(63));
        check("hold_dina", bus.dina, exp_row(63));

        // Same pattern with 50% s_valid duty, then random data with backpressure.
        clear_log();
        run_load(50, -1, -1, -1, fin);
        check_mem("bp_pattern", ROWS);
        fill_random();
        clear_log();
        run_load(50, -1, -1, -1, fin);
        check_mem("bp_random", ROWS);
        repeat (3) @(negedge clk);
        check("bp_done_once", 128'(done_cnt), 128'(1));

        // start re-pulsed while busy at row 10 is ignored.
        fill_random();
        clear_log();
        run_load(80, -1, 100, -1, fin);
        check_mem("busy_start", ROWS);
        repeat (3) @(negedge clk);
        check("busy_start_done", 128'(done_cnt), 128'(1));

        // Abort after six bytes of row 3, then a fresh load from row 0.
        fill_random();
        clear_log();
        run_load(100, 36, -1, -1, fin);
        repeat (20) @(negedge clk);
        check_mem("abort", 3);
        check("abort_no_done", 128'(done_cnt), 128'(0));
        clear_log();
        run_load(70, -1, -1, -1, fin);
        check_mem("after_abort", ROWS);

        // Asynchronous reset in the middle of row 20.
        fill_random();
        clear_log();
        run_load(100, -1, -1, 205, fin);
        repeat (20) @(negedge clk);
        check_mem("arst", 20);
        check("arst_no_done", 128'(done_cnt), 128'(0));
        fill_random();
        clear_log();
        run_load(60, -1, -1, -1, fin);
        check_mem("after_arst", ROWS);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
